demux_stream_nxw: RTL and testbench
===================================

// Module: demux_stream_nxw
// PURPOSE
//  Parametrised, registered 1-to-NUM_CH stream demultiplexer with valid/ready handshakes.
//  - Each input word goes to the output channel chosen by in_sel.
//  - Each channel has a one-entry output register, so channels stall and drain independently.
//  - Successor to the combinational 4x8 demux. Sits between a single producer and NUM_CH consumers.
// PARAMETERS
//  WIDTH   8                  data width per word/channel
//  NUM_CH  4                  number of output channels (>=2, need not be a power of 2)
//  SEL_W   $clog2(NUM_CH)     width of in_sel
//  CNT_W   8                  width of the drop counter
// PORTS
//  clk        in   1              rising-edge clock
//  rst_n      in   1              synchronous reset, active-low
//  in_data    in   WIDTH          input word
//  in_sel     in   SEL_W          destination channel index
//  in_valid   in   1              input word valid
//  in_ready   out  1              block can accept the word this cycle
//  out_data   out  NUM_CH*WIDTH   channel c data in bits [c*WIDTH +: WIDTH]
//  out_valid  out  NUM_CH         channel c holds a word
//  out_ready  in   NUM_CH         consumer c takes its word this cycle
//  err_sel    out  1              one-cycle pulse: a word with in_sel >= NUM_CH was dropped
//  drop_cnt   out  CNT_W          count of dropped words, saturating
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge): out_valid=0, out_data=0, err_sel=0, drop_cnt=0.
//    Held words are discarded. Reset takes priority over every other event.
//  - Handshakes:
//    - Input transfer = in_valid && in_ready. Channel-c transfer = out_valid[c] && out_ready[c].
//    - in_ready is combinational. For a legal sel (in_sel < NUM_CH):
//      in_ready = !out_valid[in_sel] || out_ready[in_sel]. For an illegal sel: in_ready = 1.
//    - in_ready must not depend on in_valid.
//  - Load: an accepted word with legal sel s sets out_data slice s = in_data and out_valid[s]=1
//    on the next edge. Latency is exactly 1 cycle. No combinational in->out data path.
//  - Drain: on a channel-c transfer with no load to c in the same cycle, out_valid[c]=0 and
//    slice c is cleared to 0. Unselected or idle channels read as zero.
//  - Drain and load to the same channel in one cycle: the new word replaces the old one and
//    out_valid stays 1. The result is full throughput, 1 word/cycle, on one channel.
//  - Channels are independent: any set of channels may drain in the same cycle as a load to
//    another channel.
//  - While out_valid[c]=1 and out_ready[c]=0, slice c is held stable.
//  - Illegal sel: the word is accepted and dropped. err_sel=1 for the following cycle only.
//    drop_cnt increments by 1 and saturates at 2^CNT_W-1, with no wrap.
//  - in_sel and in_data are sampled only on an input transfer; they are don't-care otherwise.
//  - No FSM beyond the per-channel FULL/EMPTY bit. Channel state transitions:
//    - EMPTY->FULL on load.
//    - FULL->EMPTY on drain without load.
//    - FULL->FULL on drain with load, or on stall.
// TESTING
//  1 Reset: drive rst_n=0 with in_valid=1 -> after the edge, out_valid=0, out_data=0, drop_cnt=0, err_sel=0.
//  2 Routing: send 8'hA5 to sel 2 with all out_ready=1 -> next cycle out_valid=4'b0100 and
//    slice 2=8'hA5; the following cycle out_valid=0 and slice 2=0.
//  3 Backpressure: out_ready[1]=0, send 8'h11 then 8'h22 to sel 1 -> 8'h11 held and in_ready=0
//    for the second word. Also, a word to sel 3 in that cycle is accepted (in_ready=1).
//  4 Full rate: out_ready[0]=1, stream 8'h01..8'h10 to sel 0 back-to-back -> in_ready stays 1
//    and channel 0 shows 16 words in order, one per cycle, after 1 cycle latency.
//  5 Illegal sel (NUM_CH=3, SEL_W=2): send sel=3 300 times -> err_sel pulses once per word,
//    no out_valid is set, and drop_cnt saturates at 8'hFF.
//  6 Mid-operation reset: with channels 0 and 2 FULL and stalled, assert rst_n=0 for 1 cycle
//    -> all out_valid=0 and out_data=0 on the next cycle, and a new load works normally after that.

Source files
------------

// File: rtl/demux_stream_nxw.sv
// Registered 1-to-NUM_CH stream demultiplexer with valid/ready handshakes.
// Each channel holds one word; illegal selects are accepted, dropped and counted.
module demux_stream_nxw #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = $clog2(NUM_CH),
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WIDTH-1:0]        in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [NUM_CH*WIDTH-1:0] out_data,
  output logic [NUM_CH-1:0]       out_valid,
  input  logic [NUM_CH-1:0]       out_ready,
  output logic                    err_sel,
  output logic [CNT_W-1:0]        drop_cnt
);

  // Handshakes: a transfer happens on a side when its valid and ready are both
  // high at a rising clk edge; in_ready never looks at in_valid.

  logic [NUM_CH-1:0] sel_hit;
  logic [NUM_CH-1:0] load;
  logic [NUM_CH-1:0] drain;
  logic [NUM_CH-1:0] valid_q;
  logic [NUM_CH-1:0] valid_nxt;
  logic [WIDTH-1:0]  data_q   [NUM_CH];
  logic [WIDTH-1:0]  data_nxt [NUM_CH];
  logic              accept;
  logic              drop;
  logic              err_q;
  logic [CNT_W-1:0]  cnt_q;

  // One-hot decode; an out-of-range select decodes to all zeros.
  always_comb begin
    sel_hit = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      sel_hit[c] = (in_sel == SEL_W'(c));
    end
  end

  // The selected channel can take a word if it is empty or draining now.
  assign in_ready = ~|(sel_hit & valid_q & ~out_ready);
  assign accept   = in_valid && in_ready;
  assign drop     = accept && !(|sel_hit);
  assign load     = {NUM_CH{accept}} & sel_hit;
  assign drain    = valid_q & out_ready;

  // Per-channel FULL/EMPTY next state; load wins over drain.
  always_comb begin
    valid_nxt = valid_q;
    for (int c = 0; c < NUM_CH; c++) begin
      data_nxt[c] = data_q[c];
      if (load[c]) begin
        valid_nxt[c] = 1'b1;
        data_nxt[c]  = in_data;
      end else if (drain[c]) begin
        valid_nxt[c] = 1'b0;
        data_nxt[c]  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        data_q[c] <= '0;
      end
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      valid_q <= valid_nxt;
      for (int c = 0; c < NUM_CH; c++) begin
        data_q[c] <= data_nxt[c];
      end
      err_q <= drop;
      if (drop && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      out_data[c*WIDTH +: WIDTH] = data_q[c];
    end
  end

  assign out_valid = valid_q;
  assign err_sel   = err_q;
  assign drop_cnt  = cnt_q;

endmodule

// File: tb/tb_demux_stream_nxw.sv
// Bench for demux_stream_nxw: directed steps plus random traffic against an
// array-based channel model; a 3-channel instance covers illegal selects.
module tb_demux_stream_nxw;

  localparam int N = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 4-channel instance
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic        err_sel;
  logic [7:0]  drop_cnt;

  // 3-channel instance
  logic [7:0]  d3_in_data;
  logic [1:0]  d3_in_sel;
  logic        d3_in_valid;
  logic        d3_in_ready;
  logic [23:0] d3_out_data;
  logic [2:0]  d3_out_valid;
  logic [2:0]  d3_out_ready;
  logic        d3_err_sel;
  logic [7:0]  d3_drop_cnt;

  demux_stream_nxw #(.WIDTH(8), .NUM_CH(4), .SEL_W(2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .err_sel(err_sel),
    .drop_cnt(drop_cnt)
  );

  demux_stream_nxw #(.WIDTH(8), .NUM_CH(3), .SEL_W(2), .CNT_W(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(d3_in_data), .in_sel(d3_in_sel),
    .in_valid(d3_in_valid), .in_ready(d3_in_ready), .out_data(d3_out_data),
    .out_valid(d3_out_valid), .out_ready(d3_out_ready), .err_sel(d3_err_sel),
    .drop_cnt(d3_drop_cnt)
  );

  // scoreboard state
  int n_checks = 0;
  int n_err    = 0;
  logic [7:0] exp_q[$];

  // reference model: one slot per channel
  logic       m_full [N];
  logic [7:0] m_data [N];
  logic       m_err;
  int         m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < N; c++) begin
      m_full[c] = 1'b0;
      m_data[c] = 8'h00;
    end
    m_err = 1'b0;
    m_cnt = 0;
  endtask

  function automatic logic m_ready();
    if (int'(in_sel) < N) return !m_full[in_sel] || out_ready[in_sel];
    return 1'b1;
  endfunction

  function automatic logic [3:0] m_valid_vec();
    logic [3:0] r;
    for (int c = 0; c < N; c++) r[c] = m_full[c];
    return r;
  endfunction

  function automatic logic [31:0] m_data_vec();
    logic [31:0] r;
    for (int c = 0; c < N; c++) r[c*8 +: 8] = m_data[c];
    return r;
  endfunction

  // driver: pre() runs mid-cycle, post() crosses the edge and checks outputs
  task automatic pre();
    #4;
    chk("in_ready", {31'd0, in_ready}, {31'd0, m_ready()});
  endtask

  task automatic post();
    logic       acc;
    logic       rst_seen;
    logic       nf [N];
    logic [7:0] nd [N];
    logic       ne;
    int         nc;
    acc = in_valid && m_ready();
    for (int c = 0; c < N; c++) begin
      nf[c] = m_full[c];
      nd[c] = m_data[c];
      if (acc && int'(in_sel) == c) begin
        nf[c] = 1'b1;
        nd[c] = in_data;
      end else if (m_full[c] && out_ready[c]) begin
        nf[c] = 1'b0;
        nd[c] = 8'h00;
      end
    end
    ne = acc && (int'(in_sel) >= N);
    nc = ne ? ((m_cnt < 255) ? m_cnt + 1 : 255) : m_cnt;
    rst_seen = !rst_n;
    @(posedge clk);
    #1;
    if (rst_seen) begin
      model_clear();
    end else begin
      for (int c = 0; c < N; c++) begin
        m_full[c] = nf[c];
        m_data[c] = nd[c];
      end
      m_err = ne;
      m_cnt = nc;
    end
    chk("out_valid", {28'd0, out_valid}, {28'd0, m_valid_vec()});
    chk("out_data", out_data, m_data_vec());
    chk("err_sel", {31'd0, err_sel}, {31'd0, m_err});
    chk("drop_cnt", {24'd0, drop_cnt}, m_cnt[31:0]);
  endtask

  task automatic cycle();
    pre();
    post();
  endtask

  initial begin
    int e3;
    int drops;
    logic v;
    logic prev_v;

    // 1: reset with valid input present on both instances
    model_clear();
    rst_n = 1'b0;
    in_valid = 1'b1; in_sel = 2'd2; in_data = 8'h5A; out_ready = 4'hF;
    d3_in_valid = 1'b1; d3_in_sel = 2'd3; d3_in_data = 8'h77; d3_out_ready = 3'b111;
    @(posedge clk);
    #1;
    chk("rst_valid", {28'd0, out_valid}, 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_err", {31'd0, err_sel}, 32'd0);
    chk("rst_cnt", {24'd0, drop_cnt}, 32'd0);
    chk("rst3_cnt", {24'd0, d3_drop_cnt}, 32'd0);
    chk("rst3_err", {31'd0, d3_err_sel}, 32'd0);
    cycle();
    rst_n = 1'b1;
    d3_in_valid = 1'b0;

    // 2: routing to channel 2
    in_valid = 1'b1; in_sel = 2'd2; in_data = 8'hA5; out_ready = 4'hF;
    cycle();
    chk("t2_valid", {28'd0, out_valid}, 32'h4);
    chk("t2_slice", {24'd0, out_data[23:16]}, 32'hA5);
    in_valid = 1'b0;
    cycle();
    chk("t2_drained", {28'd0, out_valid}, 32'h0);
    chk("t2_zero", {24'd0, out_data[23:16]}, 32'h0);

    // 3: backpressure on channel 1, channel 3 still accepts
    out_ready = 4'b1101;
    in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h11;
    cycle();
    in_data = 8'h22;
    pre();
    chk("t3_stall_ready", {31'd0, in_ready}, 32'd0);
    post();
    chk("t3_held", {24'd0, out_data[15:8]}, 32'h11);
    in_sel = 2'd3; in_data = 8'h33;
    pre();
    chk("t3_other_ready", {31'd0, in_ready}, 32'd1);
    post();
    chk("t3_ch3", {24'd0, out_data[31:24]}, 32'h33);
    chk("t3_ch1_kept", {24'd0, out_data[15:8]}, 32'h11);
    in_valid = 1'b0; out_ready = 4'hF;
    cycle();

    // 4: full rate on channel 0
    in_valid = 1'b1; in_sel = 2'd0;
    for (int i = 1; i <= 16; i++) begin
      in_data = 8'(i);
      exp_q.push_back(8'(i));
      cycle();
      chk("t4_valid0", {31'd0, out_valid[0]}, 32'd1);
      chk("t4_order", {24'd0, out_data[7:0]}, {24'd0, exp_q.pop_front()});
    end
    in_valid = 1'b0;
    cycle();
    chk("t4_empty", {31'd0, out_valid[0]}, 32'd0);

    // 5: illegal select on the 3-channel instance, saturating counter
    e3 = 0; drops = 0; prev_v = 1'b0;
    for (int i = 0; drops < 300; i++) begin
      v = (i < 30) ? (i % 3 != 2) : 1'b1;
      d3_in_valid = v; d3_in_sel = 2'd3; d3_in_data = 8'($urandom);
      d3_out_ready = 3'($urandom_range(0, 7));
      #4;
      if (i % 50 == 0) chk("t5_ready", {31'd0, d3_in_ready}, 32'd1);
      @(posedge clk);
      #1;
      if (v) begin
        drops++;
        e3 = (e3 < 255) ? e3 + 1 : 255;
      end
      if (i < 30 || drops == 300) begin
        chk("t5_err", {31'd0, d3_err_sel}, {31'd0, v});
        chk("t5_cnt", {24'd0, d3_drop_cnt}, e3[31:0]);
        chk("t5_novalid", {29'd0, d3_out_valid}, 32'd0);
      end
      prev_v = v;
    end
    d3_in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("t5_err_off", {31'd0, d3_err_sel}, 32'd0);
    chk("t5_sat", {24'd0, d3_drop_cnt}, 32'hFF);

    // 6: mid-operation reset with channels 0 and 2 stalled
    out_ready = 4'b0000;
    in_valid = 1'b1; in_sel = 2'd0; in_data = 8'hC0;
    cycle();
    in_sel = 2'd2; in_data = 8'hC2;
    cycle();
    chk("t6_full", {28'd0, out_valid}, 32'h5);
    in_valid = 1'b0; rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    chk("t6_rst_valid", {28'd0, out_valid}, 32'h0);
    chk("t6_rst_data", out_data, 32'h0);
    in_valid = 1'b1; in_sel = 2'd1; in_data = 8'hD1;
    cycle();
    chk("t6_reload", {24'd0, out_data[15:8]}, 32'hD1);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_sel    = 2'($urandom_range(0, 3));
      in_data   = 8'($urandom);
      out_ready = 4'($urandom_range(0, 15));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
